// File: rtl/dvi_decoder.sv
// TMDS receive decoder for one DVI channel: bit-slip word alignment on control-token runs,
// symbol decode back to pixel byte / control bits, and lock reporting.
module dvi_decoder #(
  parameter int unsigned TOKEN_COUNT    = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT   = 4096
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  input  logic [9:0] raw,
  output logic [7:0] data,
  output logic       de,
  output logic [1:0] control,
  output logic       locked,
  output logic [3:0] offset,
  output logic       slip
);

  localparam int unsigned MaxTimeout =
      (SEARCH_TIMEOUT > LOCK_TIMEOUT) ? SEARCH_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CntW = $clog2(MaxTimeout) + 1;

  localparam logic [CntW-1:0] TokenCount = CntW'(TOKEN_COUNT);
  localparam logic [CntW-1:0] SearchLast = CntW'(SEARCH_TIMEOUT - 1);
  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax     = {CntW{1'b1}};

  localparam logic [9:0] Tok00 = 10'b1101010100;
  localparam logic [9:0] Tok01 = 10'b0010101011;
  localparam logic [9:0] Tok10 = 10'b0101010100;
  localparam logic [9:0] Tok11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch,
    StSettle,
    StLocked
  } state_e;

  state_e state_q, state_d;

  logic [9:0]      prev_q;
  logic [9:0]      sym_q;
  logic [19:0]     window;
  logic [9:0]      aligned;

  logic [7:0]      dec_data_q, dec_data_d;
  logic            dec_de_q, dec_de_d;
  logic [1:0]      dec_ctrl_q, dec_ctrl_d;

  logic [CntW-1:0] run_q, run_d, run_next;
  logic [CntW-1:0] idle_q, idle_d, idle_next;
  logic            settle_q, settle_d;
  logic [3:0]      offset_q, offset_d;
  logic            locked_q, locked_d;
  logic            slip_q, slip_d;

  logic            is_tok;
  logic [1:0]      tok_ctrl;
  logic [7:0]      d_raw;
  logic [7:0]      dec_byte;
  logic            do_slip;
  logic            cnt_clear;

  // Earlier word occupies the low half, so bit 0 of the window is the earliest bit on the wire.
  assign window  = {raw, prev_q};
  assign aligned = window[offset_q +: 10];

  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (sym_q)
      Tok00:   tok_ctrl = 2'b00;
      Tok01:   tok_ctrl = 2'b01;
      Tok10:   tok_ctrl = 2'b10;
      Tok11:   tok_ctrl = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d_raw       = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec_byte    = '0;
    dec_byte[0] = d_raw[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = sym_q[8] ? (d_raw[i] ^ d_raw[i-1]) : ~(d_raw[i] ^ d_raw[i-1]);
    end
  end

  always_comb begin
    dec_data_d = dec_data_q;
    dec_de_d   = dec_de_q;
    dec_ctrl_d = dec_ctrl_q;
    if (is_tok) begin
      dec_data_d = 8'h00;
      dec_de_d   = 1'b0;
      dec_ctrl_d = tok_ctrl;
    end else begin
      dec_data_d = dec_byte;
      dec_de_d   = 1'b1;
    end
  end

  // dec_ctrl_q holds the previous token whenever run_q is non-zero.
  always_comb begin
    run_next = '0;
    if (is_tok) begin
      if ((run_q != '0) && (tok_ctrl == dec_ctrl_q)) begin
        run_next = (run_q >= TokenCount) ? run_q : run_q + 1'b1;
      end else begin
        run_next = {{(CntW-1){1'b0}}, 1'b1};
      end
    end
    idle_next = '0;
    if (!is_tok) begin
      idle_next = (idle_q == CntMax) ? idle_q : idle_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    locked_d  = locked_q;
    slip_d    = 1'b0;
    settle_d  = settle_q;
    do_slip   = 1'b0;
    cnt_clear = 1'b0;

    case (state_q)
      StSearch: begin
        if (run_next == TokenCount) begin
          state_d  = StLocked;
          locked_d = 1'b1;
        end else if (!is_tok && (idle_q == SearchLast)) begin
          do_slip = 1'b1;
        end
      end
      StSettle: begin
        cnt_clear = 1'b1;
        settle_d  = ~settle_q;
        if (settle_q) begin
          state_d = StSearch;
        end
      end
      StLocked: begin
        if (!is_tok && (idle_q == LockLast)) begin
          locked_d = 1'b0;
          do_slip  = 1'b1;
        end
      end
      default: begin
        state_d  = StSearch;
        locked_d = 1'b0;
      end
    endcase

    if (do_slip) begin
      offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
      slip_d    = 1'b1;
      state_d   = StSettle;
      settle_d  = 1'b0;
      cnt_clear = 1'b1;
    end

    run_d  = cnt_clear ? '0 : run_next;
    idle_d = cnt_clear ? '0 : idle_next;
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      sym_q      <= '0;
      dec_data_q <= '0;
      dec_de_q   <= 1'b0;
      dec_ctrl_q <= '0;
      run_q      <= '0;
      idle_q     <= '0;
      settle_q   <= 1'b0;
      state_q    <= StSearch;
      offset_q   <= '0;
      locked_q   <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      prev_q     <= raw;
      sym_q      <= aligned;
      dec_data_q <= dec_data_d;
      dec_de_q   <= dec_de_d;
      dec_ctrl_q <= dec_ctrl_d;
      run_q      <= run_d;
      idle_q     <= idle_d;
      settle_q   <= settle_d;
      state_q    <= state_d;
      offset_q   <= offset_d;
      locked_q   <= locked_d;
      slip_q     <= slip_d;
    end
  end

  // Decoding keeps running while unlocked; only the visible outputs are blanked.
  assign data    = locked_q ? dec_data_q : 8'h00;
  assign de      = locked_q ? dec_de_q : 1'b0;
  assign control = locked_q ? dec_ctrl_q : 2'b00;
  assign locked  = locked_q;
  assign offset  = offset_q;
  assign slip    = slip_q;

endmodule

// File: doc/dvi_decoder.md
Name: dvi_decoder

Overview:
- TMDS receive-side decoder for one DVI channel. Inverse of the channel encoder.
- Accepts unaligned 10-bit parallel words from the deserializer in the pix_clk domain.
- Aligns the words to symbol boundaries by bit-slipping until it sees runs of control tokens.
- Decodes each aligned symbol back to data/de/control and reports lock status to the downstream video-timing logic.

Parameters:
TOKEN_COUNT, 8, consecutive identical control tokens at the current offset required to declare lock
SEARCH_TIMEOUT, 4096, cycles without any control token before advancing the bit offset while searching
LOCK_TIMEOUT, 4096, cycles without any control token before dropping lock; must exceed the longest active line

Ports:
pix_clk  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
raw  in  10  deserialized word, bit 0 earliest on the wire, arbitrary word alignment
data  out  8  decoded pixel byte; valid when de=1
de  out  1  1 = data symbol, 0 = control token
control  out  2  decoded control bits (C1,C0); valid when de=0
locked  out  1  alignment locked
offset  out  4  current bit-slip offset, 0..9
slip  out  1  one-cycle pulse when offset advances

Behaviour:
- Reset (async, rst_n=0):
  - data=0, de=0, control=0, locked=0, offset=0, slip=0.
  - Pipeline registers and all counters are cleared; state=SEARCH.
  - Reset asserted mid-operation takes effect immediately and aborts lock.
- Alignment window:
  - prev is registered from raw every edge; window = {raw, prev} (20 bits).
  - aligned = window[offset+9:offset].
  - aligned is registered into sym at the next edge.
- Outputs: registered from sym one edge later.
  - Latency with offset=0: a word captured into prev at edge k appears on the outputs after edge k+2.
  - Latency is constant for a given offset.
- Control tokens (sym[9:0]):
  - 1101010100 -> control=00
  - 0010101011 -> control=01
  - 0101010100 -> control=10
  - 1010101011 -> control=11
  - On a match: de=0, data=0.
- Data symbol (any other value):
  - de=1, control holds its last value.
  - d = sym[9] ? ~sym[7:0] : sym[7:0].
  - data[0] = d[0].
  - For i=1..7: data[i] = d[i]^d[i-1] if sym[8]=1, else ~(d[i]^d[i-1]).
- While locked=0: outputs forced to data=0, de=0, control=00; decoding still runs internally.
- Counters:
  - run_cnt counts consecutive identical control tokens; a different token restarts it at 1; a data symbol clears it to 0; saturates at TOKEN_COUNT.
  - idle_cnt counts cycles since the last control token; any token clears it.
- SETTLE state: entered on every slip; lasts 2 cycles while the pipeline flushes the old offset. Both counters are held at 0; then go to SEARCH.
- SEARCH state:
  - If run_cnt reaches TOKEN_COUNT: go to LOCKED; locked=1 from the next edge.
  - Else if idle_cnt reaches SEARCH_TIMEOUT-1: slip.
- Slip action:
  - offset <= (offset==9) ? 0 : offset+1, wrapping 9->0.
  - slip=1 for one cycle; go to SETTLE.
- LOCKED state:
  - Remains while control tokens keep arriving.
  - If idle_cnt reaches LOCK_TIMEOUT-1: locked=0 on the same edge, then slip and go to SETTLE.
- Lock and timeout are mutually exclusive in one cycle, because a token clears idle_cnt.
- Arithmetic: counter width = clog2(max(SEARCH_TIMEOUT, LOCK_TIMEOUT))+1; no wrap.

Test Plan:
1. Aligned stream (offset 0), 20x token 1101010100 then data symbols 0x10F,0x2F0 -> locked=1 after the 8th token plus 2 cycles; offset=0; slip never asserted; outputs de=0/control=00 during tokens, then de=1 with data decoded per the rules above.
2. SEARCH_TIMEOUT=LOCK_TIMEOUT=64; stream rotated by 3 bits, lines of 40 data symbols plus 24x token 00 -> exactly 3 slip pulses; offset=3; locked=1; decoded bytes equal the transmitted bytes.
3. Locked link, then 70 cycles of data only (LOCK_TIMEOUT=64) -> locked drops at cycle 64; slip pulses; offset 0->1; de forced 0.
4. SEARCH at offset 9 with no tokens for 64 cycles -> offset wraps to 0, slip=1 for one cycle, followed by 2 SETTLE cycles.
5. Blanking of 7x token 00 then 1x token 01 then 8x token 00 -> no lock at the 8th token; lock after the second run of 8.
6. rst_n pulled low mid-line while locked -> all outputs 0 immediately, without waiting for a clock edge; after release, relock at offset 0.
